dshot_encoder: RTL and testbench



---
 rtl/dshot_encoder.sv | 116 +++++++++++
 tb/tb_dshot_encoder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dshot_encoder.sv
// dshot_encoder: DShot frame transmitter (11-bit throttle + telemetry bit, 4-bit CRC, duty-cycle bit coding)
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   throttle   11-bit throttle / special-command value
//   telemetry  telemetry-request bit
//   inValid    command valid
//   inReady    high only while idle; a command transfers on inValid & inReady
//   dshotPin   registered serial DShot line
//   busy       high from acceptance until the end of the inter-frame gap
//   frameDone  one-cycle pulse in the first gap cycle
// Optional: define DSHOT_INVERTED_EN for bidirectional DShot (idle high, active low, inverted CRC).
module dshot_encoder #(
   parameter int CLKS_PER_BIT = 107,
   parameter int T1H_CLKS     = 80,
   parameter int T0H_CLKS     = 40,
   parameter int GAP_CLKS     = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] throttle,
   input  logic        telemetry,
   input  logic        inValid,
   output logic        inReady,
   output logic        dshotPin,
   output logic        busy,
   output logic        frameDone
);
   localparam int CW = $clog2(CLKS_PER_BIT > GAP_CLKS ? CLKS_PER_BIT : GAP_CLKS);
`ifdef DSHOT_INVERTED_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif
   localparam logic [CW-1:0] T1_END  = CW'(T1H_CLKS - 1);
   localparam logic [CW-1:0] T0_END  = CW'(T0H_CLKS - 1);
   localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] GAP_END = CW'(GAP_CLKS - 1);

   if (!(T0H_CLKS > 0 && T0H_CLKS < T1H_CLKS && T1H_CLKS < CLKS_PER_BIT && GAP_CLKS >= 1)) begin : g_param_err
      $error("dshot_encoder: illegal timing parameters");
   end

   typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [15:0]   frame_q, frame_d;
   logic          pin_q, pin_d;
   logic [11:0]   v;
   logic [3:0]    crc;
   logic [CW-1:0] th_end;

   assign v      = {throttle, telemetry};
   assign crc    = v[11:8] ^ v[7:4] ^ v[3:0] ^ {4{INV}};
   assign th_end = frame_q[bit_q] ? T1_END : T0_END;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         frame_q <= '0;
         pin_q   <= INV;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
         pin_q   <= pin_d;
      end
   end

   // The clock counter runs on through HIGH into LOW, so each bit spans exactly CLKS_PER_BIT clocks.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      unique case (state_q)
         IDLE: if (inValid) begin
            state_d = HIGH;
            cnt_d   = '0;
            bit_d   = 4'd15;
            frame_d = {v, crc};
         end
         HIGH: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == th_end) ? LOW : HIGH;
         end
         LOW: if (cnt_q == BIT_END) begin
            cnt_d   = '0;
            state_d = (bit_q == 4'd0) ? GAP : HIGH;
            bit_d   = (bit_q == 4'd0) ? bit_q : bit_q - 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         GAP: begin
            cnt_d   = (cnt_q == GAP_END) ? '0 : cnt_q + 1'b1;
            state_d = (cnt_q == GAP_END) ? IDLE : GAP;
         end
         default: state_d = IDLE;
      endcase
   end

   // The pin register follows the next state so the first active cycle is the one after acceptance.
   always_comb begin
      inReady   = state_q == IDLE;
      busy      = state_q != IDLE;
      frameDone = state_q == GAP && cnt_q == '0;
      pin_d     = (state_d == HIGH) ? ~INV : INV;
   end

   assign dshotPin = pin_q;
endmodule

// File: tb/tb_dshot_encoder.sv
// tb_dshot_encoder: directed-vector scoreboard bench for dshot_encoder
module tb_dshot_encoder;
`ifdef DSHOT_INVERTED_EN
   localparam logic       IDL  = 1'b1;
   localparam logic [15:0] CRCX = 16'h000F;
`else
   localparam logic       IDL  = 1'b0;
   localparam logic [15:0] CRCX = 16'h0000;
`endif
   localparam logic ACT = ~IDL;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] throttle = '0;
   logic        telemetry = 1'b0;
   logic        inValid = 1'b0;
   logic        inReady, dshotPin, busy, frameDone;

   int          nvec = 0;
   int          nerr = 0;
   int          cyc = 0;
   logic [15:0] exp_q[$];

   dshot_encoder dut (
      .clk(clk), .rst_n(rst_n), .throttle(throttle), .telemetry(telemetry),
      .inValid(inValid), .inReady(inReady), .dshotPin(dshotPin), .busy(busy), .frameDone(frameDone)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      nvec++;
      if (act != req) begin
         nerr++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
      end
   endtask

   // Monitor: decodes the pin, checks timing, and compares each finished frame against the scoreboard.
   logic        prev = 1'b0, rst_low = 1'b0, in_frame = 1'b0, have_fd = 1'b0, wait_rdy = 1'b0;
   int          hi, nb, c0, last_rise, fd_cyc, bad_hi, bad_per;
   logic [15:0] dec;
   always @(negedge clk) begin
      if (!rst_n) begin
         if (rst_low) chk("reset_outputs", {dshotPin, busy, inReady, frameDone}, {IDL, 1'b0, 1'b1, 1'b0});
         rst_low  = 1'b1;
         in_frame = 1'b0;
         have_fd  = 1'b0;
         wait_rdy = 1'b0;
         exp_q.delete();
      end else begin
         rst_low = 1'b0;
         if (dshotPin == ACT) begin
            if (prev != ACT) begin
               if (!in_frame) begin
                  if (have_fd) begin
                     nvec++;
                     if (cyc - fd_cyc < 32) begin
                        nerr++;
                        $display("FAIL gap: %0d idle cycles, expected at least 32", cyc - fd_cyc);
                     end
                  end
                  in_frame = 1'b1; c0 = cyc; nb = 0; dec = '0; bad_hi = 0; bad_per = 0;
               end else if (cyc - last_rise != 107) bad_per++;
               last_rise = cyc;
               hi = 0;
            end
            hi++;
         end else if (prev == ACT && in_frame) begin
            dec = {dec[14:0], hi > 60};
            nb++;
            if (hi != 80 && hi != 40) bad_hi++;
         end
         if (frameDone) begin
            if (!in_frame) chk("unexpected_frameDone", 1, 0);
            else begin
               if (cyc - last_rise != 107) bad_per++;
               chk("frameDone_latency", cyc - c0, 1712);
               chk("bit_count", nb, 16);
               chk("high_time_violations", bad_hi, 0);
               chk("bit_period_violations", bad_per, 0);
               if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
               else chk("frame", int'(dec), int'(exp_q.pop_front()));
            end
            in_frame = 1'b0; have_fd = 1'b1; fd_cyc = cyc; wait_rdy = 1'b1;
         end
         if (wait_rdy && inReady) begin
            chk("inReady_after_frameDone", cyc - fd_cyc, 32);
            wait_rdy = 1'b0;
         end
      end
      prev = dshotPin;
   end

   task automatic send(input logic [10:0] th, input logic tl, input logic [15:0] ef);
      int n = 0;
      throttle = th; telemetry = tl; inValid = 1'b1;
      while (!inReady) begin
         @(posedge clk); #1;
         n++;
         if (n > 4000) begin
            $display("FAIL send_timeout: inReady never rose");
            $fatal(1);
         end
      end
      @(posedge clk);
      exp_q.push_back(ef ^ CRCX);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 || busy) begin
         @(posedge clk); #1;
         n++;
         if (n > 8000) begin
            $display("FAIL drain_timeout: frames still pending");
            $fatal(1);
         end
      end
      repeat (5) @(posedge clk);
      #1;
   endtask

   initial begin
      throttle = 11'h6F5; inValid = 1'b1;
      repeat (5) @(posedge clk);
      #1 inValid = 1'b0;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      send(11'h6F5, 1'b0, 16'hDEA9); inValid = 1'b0; drain();
      send(11'd2047, 1'b0, 16'hFFEE); inValid = 1'b0; drain();
      send(11'd0, 1'b0, 16'h0000);
      send(11'd2047, 1'b1, 16'hFFFF);
      send(11'd48, 1'b0, 16'h0606);
      send(11'd1000, 1'b1, 16'h7D1B);
      inValid = 1'b0;
      drain();
      send(11'd1000, 1'b1, 16'h7D1B);
      inValid = 1'b0;
      repeat (8 * 107 + 50) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      send(11'h6F5, 1'b0, 16'hDEA9); inValid = 1'b0; drain();
      repeat (40) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
